// File: rtl/imem_loader_pkg_rv32i.sv
// Shared types and constants for the RV32I instruction-memory boot loader.
package imem_loader_pkg_rv32i;

  // Bytes in one RV32I instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Width of the byte-lane counter inside one word.
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  // Loader states. IDLE is the one-cycle post-reset state; DONE is the
  // only state in which the core is released from reset.
  typedef enum logic [2:0] {
    IDLE,
    RX_LEN,
    RX_DATA,
    RX_CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/byte_assembler_rv32i.sv
// Assembles a little-endian 32-bit word from a stream of accepted bytes.
// word_valid pulses in the same cycle the fourth byte transfers, and word
// then carries the complete value including that byte, so the parent can
// act on a header or checksum at the very edge that completes it.
module byte_assembler_rv32i
  import imem_loader_pkg_rv32i::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_en,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane;
  logic [31:0]       shreg;
  logic [31:0]       shreg_next;
  logic              last_lane;

  assign last_lane = (lane == LANE_W'(BYTES_PER_WORD - 1));

  // Insert the incoming byte into its lane; the first byte lands in [7:0].
  // NOTE: every variable written in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shreg_next                = shreg;
    shreg_next[8*lane +: 8]   = byte_data;
  end

  // Lane counter and partial-word storage advance only on a transfer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (byte_en) begin
      lane  <= lane + LANE_W'(1);
      shreg <= shreg_next;
    end
  end

  assign word_valid = byte_en && last_lane;
  assign word       = shreg_next;

endmodule

// File: rtl/imem_loader_rv32i.sv
// Boot-time loader: receives a length-prefixed, checksummed byte stream,
// writes the payload words into instruction memory and releases the core
// from reset only after a load whose checksum matches.
module imem_loader_rv32i
  import imem_loader_pkg_rv32i::*;
#(
  parameter int          IMEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  // Wide enough to hold the count IMEM_DEPTH_WORDS itself, not just indices.
  localparam int CNT_W = $clog2(IMEM_DEPTH_WORDS + 1);

  state_t            state;
  state_t            state_next;

  logic              xfer;
  logic              enter_len;
  logic              word_valid;
  logic [31:0]       word;

  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  word_cnt;
  logic [31:0]       csum;

  logic              len_too_big;
  logic              len_zero;
  logic              last_word;
  logic              data_word;

  assign xfer      = rx_valid && rx_ready;
  assign enter_len = (state_next == RX_LEN) && (state != RX_LEN);

  byte_assembler_rv32i u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (enter_len),
    .byte_data  (rx_data),
    .byte_en    (xfer),
    .word_valid (word_valid),
    .word       (word)
  );

  // Header checks use the full 32-bit value so huge counts are rejected
  // rather than truncated into the counter width.
  assign len_too_big = (word > 32'(IMEM_DEPTH_WORDS));
  assign len_zero    = (word == 32'd0);
  assign last_word   = ((word_cnt + CNT_W'(1)) == n_words);
  assign data_word   = (state == RX_DATA) && word_valid;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; transitions happen on the edge that completes a word.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = RX_LEN;
      RX_LEN: begin
        if (word_valid) begin
          if (len_too_big)   state_next = ERROR;
          else if (len_zero) state_next = RX_CSUM;
          else               state_next = RX_DATA;
        end
      end
      RX_DATA: begin
        if (word_valid && last_word) state_next = RX_CSUM;
      end
      RX_CSUM: begin
        if (word_valid) state_next = (word == csum) ? DONE : ERROR;
      end
      DONE:    if (load_req) state_next = RX_LEN;
      ERROR:   if (load_req) state_next = RX_LEN;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    rx_ready   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    cpu_reset  = 1'b1;
    unique case (state)
      RX_LEN, RX_DATA, RX_CSUM: rx_ready   = 1'b1;
      DONE: begin
        load_done = 1'b1;
        cpu_reset = 1'b0;
      end
      ERROR:                    load_error = 1'b1;
      default: ;
    endcase
  end

  // Header length, word index and running checksum of the payload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_words  <= '0;
      word_cnt <= '0;
      csum     <= '0;
    end else if (enter_len) begin
      n_words  <= '0;
      word_cnt <= '0;
      csum     <= '0;
    end else begin
      if ((state == RX_LEN) && word_valid) begin
        n_words <= word[CNT_W-1:0];
      end
      if (data_word) begin
        word_cnt <= word_cnt + CNT_W'(1);
        csum     <= csum + word;
      end
    end
  end

  // Registered write port: one strobe the cycle after each payload word
  // completes. Address and data hold their last values between writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= data_word;
      if (data_word) begin
        imem_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
        imem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Self-checking bench for imem_loader_rv32i. Expected imem writes are
// queued as each stream is built; a monitor records actual writes and each
// scenario compares the two queues plus the decoded status outputs.
module tb_imem_loader_rv32i;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_req;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  // Status vector order: {load_done, load_error, cpu_reset, rx_ready}.
  localparam logic [3:0] ST_IDLE  = 4'b0010;
  localparam logic [3:0] ST_RECV  = 4'b0011;
  localparam logic [3:0] ST_DONE  = 4'b1000;
  localparam logic [3:0] ST_ERROR = 4'b0110;

  imem_loader_rv32i #(
    .IMEM_DEPTH_WORDS (1024),
    .BASE_ADDR        (32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset && imem_we) got_q.push_back({imem_addr, imem_wdata});
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] status();
    return {load_done, load_error, cpu_reset, rx_ready};
  endfunction

  // Offer one byte after 0..max_gap idle cycles; waits (bounded) for ready.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  accepted;
    gap      = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    accepted = 1'b0;
    repeat (gap) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 64 && !accepted; i++) begin
      if (rx_ready) accepted = 1'b1;
      @(negedge clock);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_accept: byte %02h got rx_ready=0 for 64 cycles, required 1", b);
    end
  endtask

  task automatic send_stream(input int max_gap);
    while (stream_q.size() > 0) send_byte(stream_q.pop_front(), max_gap);
  endtask

  task automatic request_reload();
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  // Normal two-word program; checksum 0x00500093 + 0x00108113 = 0x006081A6.
  task automatic build_normal_stream();
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h81, 8'h10, 8'h00,
                 8'hA6, 8'h81, 8'h60, 8'h00};
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_8113});
  endtask

  // Compare recorded writes against the expected queue, then empty both.
  task automatic drain_scoreboard(input string name);
    logic [63:0] e;
    logic [63:0] g;
    repeat (2) @(negedge clock);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL %s write_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL %s write: got addr=%08h data=%08h, required addr=%08h data=%08h",
                 name, g[63:32], g[31:0], e[63:32], e[31:0]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (status() !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_status: got %04b, required %04b", status(), ST_IDLE);
    end
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata} !== 65'd0) begin
      n_errors++;
      $display("FAIL reset_write_port: got we=%0b addr=%08h data=%08h, required all zero",
               imem_we, imem_addr, imem_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (status() !== ST_RECV) begin
      n_errors++;
      $display("FAIL reset_to_rx_len: got %04b, required %04b", status(), ST_RECV);
    end
  endtask

  task automatic test_normal_load();
    build_normal_stream();
    send_stream(0);
    n_checks++;
    if (status() !== ST_DONE) begin
      n_errors++;
      $display("FAIL normal_status: got %04b, required %04b", status(), ST_DONE);
    end
    drain_scoreboard("normal");
  endtask

  task automatic test_reload();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reload_edge: got cpu_reset=%0b load_done=%0b, required 1 0", cpu_reset, load_done);
    end
    @(negedge clock);
    load_req = 1'b0;
    stream_q = '{8'h01, 8'h00, 8'h00, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_stream(0);
    n_checks++;
    if (status() !== ST_DONE) begin
      n_errors++;
      $display("FAIL reload_status: got %04b, required %04b", status(), ST_DONE);
    end
    drain_scoreboard("reload");
  endtask

  task automatic test_bad_checksum();
    request_reload();
    build_normal_stream();
    void'(stream_q.pop_back());
    stream_q.push_back(8'h01);
    send_stream(0);
    n_checks++;
    if (status() !== ST_ERROR) begin
      n_errors++;
      $display("FAIL bad_csum_status: got %04b, required %04b", status(), ST_ERROR);
    end
    drain_scoreboard("bad_csum");
    // A stray byte offered in ERROR must not be taken.
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(negedge clock);
    rx_valid = 1'b0;
    n_checks++;
    if (status() !== ST_ERROR) begin
      n_errors++;
      $display("FAIL error_hold: got %04b, required %04b", status(), ST_ERROR);
    end
  endtask

  task automatic test_zero_count();
    request_reload();
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    n_checks++;
    if (status() !== ST_DONE) begin
      n_errors++;
      $display("FAIL zero_count_status: got %04b, required %04b", status(), ST_DONE);
    end
    drain_scoreboard("zero_count");
  endtask

  task automatic test_overflow();
    request_reload();
    stream_q = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_stream(0);
    n_checks++;
    if (status() !== ST_ERROR) begin
      n_errors++;
      $display("FAIL overflow_status: got %04b, required %04b", status(), ST_ERROR);
    end
    drain_scoreboard("overflow");
  endtask

  task automatic test_gaps();
    request_reload();
    build_normal_stream();
    send_stream(7);
    n_checks++;
    if (status() !== ST_DONE) begin
      n_errors++;
      $display("FAIL gaps_status: got %04b, required %04b", status(), ST_DONE);
    end
    drain_scoreboard("gaps");
  endtask

  task automatic test_reset_mid_stream();
    request_reload();
    build_normal_stream();
    for (int i = 0; i < 6; i++) send_byte(stream_q.pop_front(), 0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (status() !== ST_IDLE) begin
      n_errors++;
      $display("FAIL midreset_status: got %04b, required %04b", status(), ST_IDLE);
    end
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata} !== 65'd0) begin
      n_errors++;
      $display("FAIL midreset_write_port: got we=%0b addr=%08h data=%08h, required all zero",
               imem_we, imem_addr, imem_wdata);
    end
    @(negedge clock);
    reset = 1'b0;
    stream_q.delete();
    exp_q.delete();
    drain_scoreboard("midreset_partial");
    build_normal_stream();
    send_stream(0);
    n_checks++;
    if (status() !== ST_DONE) begin
      n_errors++;
      $display("FAIL midreset_restream_status: got %04b, required %04b", status(), ST_DONE);
    end
    drain_scoreboard("midreset_restream");
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_reload();
    test_bad_checksum();
    test_zero_count();
    test_overflow();
    test_gaps();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
